// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall unit: syscall codes, FSM state encoding
// and the ASCII constants used by the console path.
package syscall_pkg;

    localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
    localparam logic [31:0] SYS_EXIT       = 32'd10;
    localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
    localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_X = 8'h78;

    typedef enum logic [2:0] {
        IDLE,
        STR_REQ,
        STR_WAIT,
        STR_EMIT,
        INT_EMIT,
        CHAR_EMIT,
        HALTED,
        HEX_EMIT
    } state_t;

endpackage

// File: rtl/syscall_unit_hex_to_ascii.sv
// Converts one 4-bit nibble to its uppercase ASCII hex digit.
module hex_to_ascii
    import syscall_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10)
            ascii = ASCII_0 + {4'h0, nibble};
        else
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
    end

endmodule

// File: rtl/syscall_unit.sv
// Multi-cycle console syscall executor (print int/string/char, exit) that stalls the CPU while busy.
// Optional print-hex syscall (v0=34) is enabled by defining SYSCALL_PRINT_HEX_EN.
module syscall_unit
    import syscall_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned MAX_STR_LEN = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall,
    input  logic [31:0]       v0,
    input  logic [ADDR_W-1:0] a0,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_valid,
    output logic [7:0]        char_data,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [31:0]       int_data,
    output logic              int_valid,
    input  logic              int_ready,
    output logic              halt,
    output logic              bad_code
);

    localparam int unsigned CNT_W = $clog2(MAX_STR_LEN + 1);

    state_t            state, state_next;
    logic              done;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  count;
    logic              start;
    logic              is_int, is_char, is_str, is_exit, is_hex, is_bad;
    logic              str_end;

    assign start   = (state == IDLE) && syscall && !done;
    assign is_int  = (v0 == SYS_PRINT_INT);
    assign is_char = (v0 == SYS_PRINT_CHAR);
    assign is_str  = (v0 == SYS_PRINT_STR);
    assign is_exit = (v0 == SYS_EXIT);
`ifdef SYSCALL_PRINT_HEX_EN
    assign is_hex  = (v0 == SYS_PRINT_HEX);
`else
    assign is_hex  = 1'b0;
`endif
    assign is_bad  = start && !(is_int || is_char || is_str || is_exit || is_hex);
    assign str_end = (mem_rdata == 8'h00) || (count == CNT_W'(MAX_STR_LEN));

`ifdef SYSCALL_PRINT_HEX_EN
    logic [31:0] hex_val;
    logic [3:0]  digit;
    logic [31:0] hex_shift;
    logic [7:0]  hex_ascii;
    logic [7:0]  hex_next;

    // Digit k (2..9) shows nibble 9-k; the next char is prepared while the current one is offered.
    assign hex_shift = hex_val >> {4'd8 - digit, 2'b00};
    assign hex_next  = (digit == 4'd0) ? ASCII_X : hex_ascii;

    hex_to_ascii u_hex_to_ascii (
        .nibble (hex_shift[3:0]),
        .ascii  (hex_ascii)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_int)       state_next = INT_EMIT;
                    else if (is_char) state_next = CHAR_EMIT;
                    else if (is_str)  state_next = STR_REQ;
                    else if (is_exit) state_next = HALTED;
                    else if (is_hex)  state_next = HEX_EMIT;
                end
            end
            STR_REQ:   state_next = STR_WAIT;
            STR_WAIT:  if (mem_valid) state_next = str_end ? IDLE : STR_EMIT;
            STR_EMIT:  if (char_ready) state_next = STR_REQ;
            INT_EMIT:  if (int_ready) state_next = IDLE;
            CHAR_EMIT: if (char_ready) state_next = IDLE;
            HALTED:    state_next = HALTED;
`ifdef SYSCALL_PRINT_HEX_EN
            HEX_EMIT:  if (char_ready && digit == 4'd9) state_next = IDLE;
`endif
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        stall      = (state != IDLE) || start;
        mem_req    = (state == STR_REQ);
        char_valid = (state == CHAR_EMIT) || (state == STR_EMIT) || (state == HEX_EMIT);
        int_valid  = (state == INT_EMIT);
        halt       = (state == HALTED);
    end

    assign mem_addr = ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_data  <= '0;
            char_data <= '0;
            ptr       <= '0;
            count     <= '0;
            bad_code  <= 1'b0;
            done      <= 1'b0;
`ifdef SYSCALL_PRINT_HEX_EN
            hex_val   <= '0;
            digit     <= '0;
`endif
        end else begin
            bad_code <= is_bad;
            // Done blocks re-execution of a still-held syscall once the FSM is back in IDLE.
            if ((state != IDLE && state_next == IDLE) || is_bad)
                done <= 1'b1;
            else if (!syscall)
                done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_int)  int_data  <= 32'(a0);
                        if (is_char) char_data <= a0[7:0];
                        if (is_str) begin
                            ptr   <= a0;
                            count <= '0;
                        end
`ifdef SYSCALL_PRINT_HEX_EN
                        if (is_hex) begin
                            hex_val   <= 32'(a0);
                            digit     <= '0;
                            char_data <= ASCII_0;
                        end
`endif
                    end
                end
                STR_WAIT: if (mem_valid && !str_end) char_data <= mem_rdata;
                STR_EMIT: begin
                    if (char_ready) begin
                        ptr   <= ptr + 1'b1;
                        count <= count + 1'b1;
                    end
                end
`ifdef SYSCALL_PRINT_HEX_EN
                HEX_EMIT: begin
                    if (char_ready && digit != 4'd9) begin
                        digit     <= digit + 4'd1;
                        char_data <= hex_next;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
